// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults, requester indices and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned WORDS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = 5;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned NUM_REQ  = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_req_t;

    // Mask keeping only the low aw bits of a 32-bit register address.
    function automatic logic [31:0] addr_mask(input int unsigned aw);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < aw) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flop moves only when a grant is issued.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: favour whichever side did not win last time.
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[1]) begin
            last_d = 1'b1;
        end else if (gnt_o[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and tracks
// pending destination registers so issue can stall on unresolved sources.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned WORDS = WORDS_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_data,
    input  logic        iss_valid,
    input  logic [31:0] iss_addr,
    input  logic [31:0] rs0_addr,
    input  logic [31:0] rs1_addr,
    input  logic        flush,
    output logic        stall,
    output logic        write_en,
    output logic [31:0] w0_addr,
    output logic [31:0] w0
);

    localparam logic [31:0] AddrMask = addr_mask(AW);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] gnt;
    wb_req_t            req_alu;
    wb_req_t            req_load;
    wb_req_t            sel;
    logic               xfer;
    logic               in_range;
    logic               wr;

    logic [WORDS-1:0]   pending_q, pending_d;
    logic               write_en_q, write_en_d;
    logic [31:0]        w0_addr_q, w0_addr_d;
    logic [31:0]        w0_q, w0_d;

    assign req_valid[REQ_ALU]  = req0_valid;
    assign req_valid[REQ_LOAD] = req1_valid;
    assign req_alu             = '{addr: req0_addr, data: req0_data};
    assign req_load            = '{addr: req1_addr, data: req1_data};

    rr_arb2 u_rr_arb2 (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (req_valid),
        .gnt_o (gnt)
    );

    // Gating ready with reset aborts any transfer in the cycle reset rises.
    assign req0_ready = gnt[REQ_ALU] & ~reset;
    assign req1_ready = gnt[REQ_LOAD] & ~reset;

    assign xfer     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel      = gnt[REQ_LOAD] ? req_load : req_alu;
    assign in_range = (sel.addr < WORDS);
    assign wr       = xfer & in_range;

    // Ordering gives flush < clear-on-writeback < set-on-issue priority.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (wr && (sel.addr == i)) begin
                pending_d[i] = 1'b0;
            end
            if (iss_valid && (iss_addr == i)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Out-of-range source addresses never match an index, so they contribute 0.
    always_comb begin
        stall = 1'b0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if ((rs0_addr == i) || (rs1_addr == i)) begin
                stall = stall | pending_q[i];
            end
        end
    end

    always_comb begin
        write_en_d = wr;
        w0_addr_d  = w0_addr_q;
        w0_d       = w0_q;
        if (wr) begin
            w0_addr_d = sel.addr & AddrMask;
            w0_d      = sel.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            write_en_q <= 1'b0;
            w0_addr_q  <= '0;
            w0_q       <= '0;
        end else begin
            pending_q  <= pending_d;
            write_en_q <= write_en_d;
            w0_addr_q  <= w0_addr_d;
            w0_q       <= w0_d;
        end
    end

    assign write_en = write_en_q;
    assign w0_addr  = w0_addr_q;
    assign w0       = w0_q;

endmodule
